// File: rtl/control_unit_if.sv
// control_unit_if: instruction fields and ALU flags in, datapath control signals out.
interface control_unit_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       neg;
  logic       pc_src;
  logic       result_src;
  logic [1:0] mem_rdwr;
  logic       alu_src;
  logic       regwrite;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  modport master (
    output opcode, funct3, funct7_5, zero, neg,
    input  pc_src, result_src, mem_rdwr, alu_src, regwrite, imm_src, alu_ctrl
  );
  modport slave (
    input  opcode, funct3, funct7_5, zero, neg,
    output pc_src, result_src, mem_rdwr, alu_src, regwrite, imm_src, alu_ctrl
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: single-cycle RV32I decoder with branch resolution and a reset-held enable.
package controls;
  typedef enum logic [1:0] {MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10} mem_op;
  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100} Imm_ex_op;
  typedef enum logic [3:0] {
    ADD = 4'b0000, SUB = 4'b0001, SLL = 4'b0010, SLT = 4'b0011, SLTU = 4'b0100,
    XOR = 4'b0101, SRL = 4'b0110, SRA = 4'b0111, OR = 4'b1000, AND = 4'b1001
  } alu_op;
endpackage

module control_unit
  import controls::*;
#(
  parameter int rom_bits = 16
) (
  input logic         clk,
  input logic         reset,
  control_unit_if.slave bus
);
  logic                en_q, en_d;
  logic [rom_bits-1:0] rom;
  logic [10:0]         cw;
  logic                is_r, cond;
  alu_op               fn_alu, alu;
  assign en_d = !reset;
  always_ff @(posedge clk) begin
    en_q <= en_d;
  end
  // word: [10:9] alu class, [8:6] imm, [5] branch, [4] result_src, [3:2] mem, [1] alu_src, [0] regwrite
  always_comb begin
    rom = '0;
    case (bus.opcode)
      7'b0110011: rom[10:0] = 11'b10_000_0_0_00_0_1;
      7'b0010011: rom[10:0] = 11'b10_000_0_0_00_1_1;
      7'b0000011: rom[10:0] = 11'b00_000_0_1_01_1_1;
      7'b0100011: rom[10:0] = 11'b00_001_0_0_10_1_0;
      7'b1100011: rom[10:0] = 11'b01_010_1_0_00_0_0;
      default:    rom = '0;
    endcase
  end
  assign cw = rom[10:0];
  if (rom_bits > 11) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rom[rom_bits-1:11];
  end
  assign is_r = bus.opcode == 7'b0110011;
  always_comb begin
    fn_alu = ADD;
    case (bus.funct3)
      3'b000:  fn_alu = (is_r && bus.funct7_5) ? SUB : ADD;
      3'b001:  fn_alu = SLL;
      3'b010:  fn_alu = SLT;
      3'b011:  fn_alu = SLTU;
      3'b100:  fn_alu = XOR;
      3'b101:  fn_alu = bus.funct7_5 ? SRA : SRL;
      3'b110:  fn_alu = OR;
      default: fn_alu = AND;
    endcase
  end
  assign alu  = cw[10] ? fn_alu : (cw[9] ? SUB : ADD);
  // funct3[0] inverts the sense; 010/011 never branch
  assign cond = bus.funct3[2] ? (bus.neg ^ bus.funct3[0])
                              : (!bus.funct3[1] && (bus.zero ^ bus.funct3[0]));
  assign bus.pc_src     = en_q && cw[5] && cond;
  assign bus.result_src = en_q && cw[4];
  assign bus.mem_rdwr   = en_q ? cw[3:2] : MEM_NONE;
  assign bus.alu_src    = en_q && cw[1];
  assign bus.regwrite   = en_q && cw[0];
  assign bus.imm_src    = en_q ? cw[8:6] : IMM_I;
  assign bus.alu_ctrl   = en_q ? alu : ADD;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction vectors with a queue-based scoreboard and negedge monitor.
module tb_control_unit;
  import controls::*;
  logic clk = 0;
  logic reset = 1;
  control_unit_if bus();
  control_unit #(.rom_bits(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  localparam logic [31:0] I_ADD = 32'h015A04B3;
  function automatic logic [12:0] w(input logic pc, input logic rs, input logic [1:0] m,
                                    input logic as, input logic rw, input logic [2:0] imm,
                                    input logic [3:0] alu);
    return {pc, rs, m, as, rw, imm, alu};
  endfunction
  task automatic apply(input logic [31:0] instr, input logic z, input logic n, input logic r,
                       input logic [12:0] e, input string nm);
    @(posedge clk);
    #1;
    reset        = r;
    bus.opcode   = instr[6:0];
    bus.funct3   = instr[14:12];
    bus.funct7_5 = instr[30];
    bus.zero     = z;
    bus.neg      = n;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [12:0] e, got;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      got = {bus.pc_src, bus.result_src, bus.mem_rdwr, bus.alu_src, bus.regwrite, bus.imm_src, bus.alu_ctrl};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got %b required %b", nm, got, e);
      end
    end
  end
  initial begin
    logic [12:0] safe, add_e;
    safe  = w(0, 0, MEM_NONE, 0, 0, IMM_I, ADD);
    add_e = w(0, 0, MEM_NONE, 0, 1, IMM_I, ADD);
    bus.opcode = 7'h33; bus.funct3 = 0; bus.funct7_5 = 0; bus.zero = 1; bus.neg = 1;
    apply(I_ADD, 1, 1, 1, safe, "reset_cycle0");
    apply(I_ADD, 1, 1, 1, safe, "reset_cycle1");
    apply(I_ADD, 1, 1, 0, safe, "release_still_off");
    apply(I_ADD, 1, 1, 0, add_e, "add");
    apply(32'hCB910193, 0, 0, 0, w(0, 0, MEM_NONE, 1, 1, IMM_I, ADD), "addi_f7set");
    apply(32'h00812703, 0, 1, 0, w(0, 1, MEM_READ, 1, 1, IMM_I, ADD), "lw");
    apply(32'h00E12423, 1, 1, 0, w(0, 0, MEM_WRITE, 1, 0, IMM_S, ADD), "sw");
    apply(32'h00A5C663, 0, 1, 0, w(1, 0, MEM_NONE, 0, 0, IMM_B, SUB), "blt_taken");
    apply(32'h00A5C663, 1, 0, 0, w(0, 0, MEM_NONE, 0, 0, IMM_B, SUB), "blt_not_taken");
    apply(32'h00B50463, 1, 0, 0, w(1, 0, MEM_NONE, 0, 0, IMM_B, SUB), "beq_zero1");
    apply(32'h00B50463, 0, 1, 0, w(0, 0, MEM_NONE, 0, 0, IMM_B, SUB), "beq_zero0");
    apply(32'h00B51463, 1, 0, 0, w(0, 0, MEM_NONE, 0, 0, IMM_B, SUB), "bne_zero1");
    apply(32'h00B51463, 0, 0, 0, w(1, 0, MEM_NONE, 0, 0, IMM_B, SUB), "bne_zero0");
    apply(32'h00A5D663, 0, 0, 0, w(1, 0, MEM_NONE, 0, 0, IMM_B, SUB), "bge_taken");
    apply(32'h00A5E663, 0, 1, 0, w(1, 0, MEM_NONE, 0, 0, IMM_B, SUB), "bltu_taken");
    apply(32'h00A5F663, 0, 1, 0, w(0, 0, MEM_NONE, 0, 0, IMM_B, SUB), "bgeu_not_taken");
    apply(32'h00A5A663, 1, 1, 0, w(0, 0, MEM_NONE, 0, 0, IMM_B, SUB), "branch_f3_010");
    apply(32'h4020D1B3, 0, 0, 0, w(0, 0, MEM_NONE, 0, 1, IMM_I, SRA), "sra");
    apply(32'h0020D1B3, 0, 0, 0, w(0, 0, MEM_NONE, 0, 1, IMM_I, SRL), "srl");
    apply(32'h4030D093, 0, 0, 0, w(0, 0, MEM_NONE, 1, 1, IMM_I, SRA), "srai");
    apply(32'h40B50533, 1, 1, 0, w(0, 0, MEM_NONE, 0, 1, IMM_I, SUB), "sub");
    apply(32'h0FF57513, 0, 0, 0, w(0, 0, MEM_NONE, 1, 1, IMM_I, AND), "andi");
    apply(32'h00B54533, 0, 0, 0, w(0, 0, MEM_NONE, 0, 1, IMM_I, XOR), "xor");
    apply(32'h0000007F, 1, 1, 0, safe, "illegal_opcode");
    apply(I_ADD, 1, 1, 1, add_e, "reset_same_cycle");
    apply(I_ADD, 1, 1, 0, safe, "reset_forced");
    apply(I_ADD, 1, 1, 0, add_e, "reset_recovered");
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
